// File: rtl/nanosoc_target_output_rr_if.sv
// Bus bundle between the input-stage ports, the output stage and one target.
// The output stage uses the master modport; the target side uses slave.
interface nanosoc_target_output_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MASTER_W  = 4
);
  // per-port held address/control, port i at slice i
  logic [NUM_PORTS-1:0]          sel_op;
  logic [2*NUM_PORTS-1:0]        trans_op;
  logic [NUM_PORTS-1:0]          write_op;
  logic [3*NUM_PORTS-1:0]        size_op;
  logic [3*NUM_PORTS-1:0]        burst_op;
  logic [4*NUM_PORTS-1:0]        prot_op;
  logic [MASTER_W*NUM_PORTS-1:0] master_op;
  logic [NUM_PORTS-1:0]          mastlock_op;
  logic [NUM_PORTS-1:0]          held_tran_op;
  logic [ADDR_W*NUM_PORTS-1:0]   addr_op;
  logic [DATA_W*NUM_PORTS-1:0]   wdata_op;
  logic [NUM_PORTS-1:0]          active_op;
  // shared target port
  logic                          HSELM;
  logic [ADDR_W-1:0]             HADDRM;
  logic [1:0]                    HTRANSM;
  logic                          HWRITEM;
  logic [2:0]                    HSIZEM;
  logic [2:0]                    HBURSTM;
  logic [3:0]                    HPROTM;
  logic [MASTER_W-1:0]           HMASTERM;
  logic                          HMASTLOCKM;
  logic                          HREADYMUXM;
  logic [DATA_W-1:0]             HWDATAM;
  logic                          HREADYOUTM;

  modport master (
    input  sel_op, trans_op, write_op, size_op, burst_op, prot_op, master_op,
           mastlock_op, held_tran_op, addr_op, wdata_op, HREADYOUTM,
    output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
  );

  modport slave (
    output sel_op, trans_op, write_op, size_op, burst_op, prot_op, master_op,
           mastlock_op, held_tran_op, addr_op, wdata_op, HREADYOUTM,
    input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
  );
endinterface

// File: rtl/nanosoc_target_output_rr.sv
// AHB-Lite bus-matrix output stage: round-robin burst arbiter that muxes
// NUM_PORTS input-stage ports onto one target, honouring fixed-length bursts,
// INCR bursts, HMASTLOCK sequences and a per-port connectivity mask.
module nanosoc_target_output_rr #(
  parameter int                   NUM_PORTS = 4,
  parameter int                   ADDR_W    = 32,
  parameter int                   DATA_W    = 32,
  parameter int                   MASTER_W  = 4,
  parameter logic [NUM_PORTS-1:0] PORT_MASK = {NUM_PORTS{1'b1}}
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  nanosoc_target_output_rr_if.master bus
);
  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic                 no_port;
  logic [PW-1:0]        addr_port;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        data_port;
  logic [3:0]           beats_left;
  logic [3:0]           beats_next;
  logic                 hsel_lock;
  logic                 wdata_phase;
  logic                 slave_sel;
  logic                 ready;
  logic [NUM_PORTS-1:0] req;
  logic                 found;
  logic [PW-1:0]        winner;
  logic                 hold_lock;
  logic                 hold_burst;
  logic                 hold_incr;
  logic                 hold;

  assign req   = bus.held_tran_op & bus.sel_op & PORT_MASK;
  assign ready = slave_sel ? bus.HREADYOUTM : 1'b1;
  assign bus.HREADYMUXM = ready;

  // Address/control mux from the granted port; everything quiet when no owner.
  always_comb begin
    bus.active_op  = '0;
    bus.HSELM      = 1'b0;
    bus.HADDRM     = '0;
    bus.HTRANSM    = TRANS_IDLE;
    bus.HWRITEM    = 1'b0;
    bus.HSIZEM     = '0;
    bus.HBURSTM    = '0;
    bus.HPROTM     = '0;
    bus.HMASTERM   = '0;
    bus.HMASTLOCKM = 1'b0;
    if (!no_port) begin
      bus.active_op[addr_port] = 1'b1;
      bus.HSELM      = bus.sel_op[addr_port];
      bus.HADDRM     = bus.addr_op[addr_port*ADDR_W +: ADDR_W];
      bus.HTRANSM    = bus.trans_op[addr_port*2 +: 2];
      bus.HWRITEM    = bus.write_op[addr_port];
      bus.HSIZEM     = bus.size_op[addr_port*3 +: 3];
      bus.HBURSTM    = bus.burst_op[addr_port*3 +: 3];
      bus.HPROTM     = bus.prot_op[addr_port*4 +: 4];
      bus.HMASTERM   = bus.master_op[addr_port*MASTER_W +: MASTER_W];
      bus.HMASTLOCKM = bus.mastlock_op[addr_port];
    end
  end

  // Write data follows the port that owned the previous accepted address phase.
  always_comb begin
    bus.HWDATAM = '0;
    if (wdata_phase) bus.HWDATAM = bus.wdata_op[data_port*DATA_W +: DATA_W];
  end

  // Remaining fixed-length beats after this cycle's accepted transfer.
  always_comb begin
    beats_next = beats_left;
    if (ready && bus.HSELM) begin
      case (bus.HTRANSM)
        TRANS_NONSEQ: begin
          case (bus.HBURSTM)
            3'b010, 3'b011: beats_next = 4'd3;
            3'b100, 3'b101: beats_next = 4'd7;
            3'b110, 3'b111: beats_next = 4'd15;
            default:        beats_next = beats_left;
          endcase
        end
        TRANS_SEQ:  if (beats_left != 4'd0) beats_next = beats_left - 4'd1;
        TRANS_IDLE: beats_next = 4'd0;
        default:    beats_next = beats_left;
      endcase
    end
  end

  // Round-robin scan starting after the last winner, last winner checked last.
  always_comb begin : rr_scan
    int idx;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // Conditions that keep the current owner for another address phase.
  always_comb begin
    hold_lock  = bus.HMASTLOCKM & (hsel_lock | bus.HSELM);
    hold_burst = (beats_next != 4'd0);
    hold_incr  = !no_port && (bus.HBURSTM == BURST_INCR) &&
                 (bus.HTRANSM != TRANS_IDLE) && req[addr_port];
    hold       = hold_lock | hold_burst | hold_incr;
  end

  // Grant, burst, lock and data-phase state; all frozen during wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      no_port     <= 1'b1;
      addr_port   <= '0;
      rr_ptr      <= PW'(NUM_PORTS - 1);
      beats_left  <= 4'd0;
      hsel_lock   <= 1'b0;
      data_port   <= '0;
      wdata_phase <= 1'b0;
      slave_sel   <= 1'b0;
    end else if (ready) begin
      beats_left  <= beats_next;
      data_port   <= addr_port;
      wdata_phase <= bus.HSELM & bus.HTRANSM[1];
      slave_sel   <= bus.HSELM;
      if (bus.HSELM && bus.HTRANSM[1] && bus.HMASTLOCKM) hsel_lock <= 1'b1;
      else if (!bus.HMASTLOCKM)                          hsel_lock <= 1'b0;
      if (!hold) begin
        if (found) begin
          no_port   <= 1'b0;
          addr_port <= winner;
          rr_ptr    <= winner;
        end else begin
          no_port   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/nanosoc_target_output_rr.md
# nanosoc_target_output_rr

Parametrised AHB-Lite bus-matrix output stage for the nanosoc interconnect: multiplexes up to NUM_PORTS input-stage ports onto one shared target port. It contains its own round-robin burst arbiter with a fixed-length beat counter, HMASTLOCK hold and a sparse-connectivity mask. It replaces the per-target, hand-instantiated output-stage/arbiter pairs.

## Interface
- NUM_PORTS, 4, number of input-stage ports (2..8); PW = clog2(NUM_PORTS)
- ADDR_W, 32, address width
- DATA_W, 32, write-data width
- MASTER_W, 4, HMASTER width
- PORT_MASK, {NUM_PORTS{1'b1}}, bit i=1 means port i is connected; unconnected ports never granted
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset; asynchronous, active-low
- sel_op, trans_op, write_op, size_op, burst_op, prot_op, master_op, mastlock_op, held_tran_op  in  NUM_PORTS×{1,2,1,3,3,4,MASTER_W,1,1}  per-port held address/control, packed with port i at slice i
- addr_op  in  NUM_PORTS*ADDR_W  per-port address
- wdata_op  in  NUM_PORTS*DATA_W  per-port write data
- HREADYOUTM  in  1  target HREADYOUT
- active_op  out  NUM_PORTS  one-hot address-phase owner
- HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTERM, HMASTLOCKM  out  1/ADDR_W/2/1/3/3/4/MASTER_W/1  target address/control
- HREADYMUXM  out  1  target HREADY
- HWDATAM  out  DATA_W  target write data

## Operation
- req[i] = held_tran_op[i] & sel_op[i] & PORT_MASK[i].
- Registered grant: addr_port (PW bits) and no_port. Outputs mux from addr_port when !no_port; otherwise all address/control outputs are 0 and active_op = 0.
- Arbitration is evaluated only when HREADYMUXM=1; the result applies from the next cycle.
- The owner is held (no re-arbitration) if any of the following is true:
  - hold_lock: hlock_arb = i_hmastlockm & (hsel_lock | i_hselm) is 1.
  - hold_burst: beats_left after this cycle's update is non-zero.
  - hold_incr: HBURSTM=INCR(001), HTRANSM!=IDLE and req[owner]=1.
- Otherwise the grant goes to the first requesting port scanning rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS, including rr_ptr itself last. rr_ptr is loaded with the winner. If no port requests, no_port=1 and addr_port/rr_ptr are unchanged.
- Beat counter beats_left (4 bits) updates on HREADYMUXM=1 with HSELM=1:
  - NONSEQ with HBURSTM in {WRAP4, INCR4}: load 3; {WRAP8, INCR8}: load 7; {WRAP16, INCR16}: load 15.
  - SEQ with beats_left!=0: decrement.
  - IDLE: clear to 0 (early-terminated burst).
  - Any other case: unchanged.
- hsel_lock updates on HREADYMUXM=1: set when HSELM & HTRANSM[1] & HMASTLOCKM; cleared when HMASTLOCKM=0; else held.
- Data phase: data_port <= addr_port and wdata_phase <= HSELM & HTRANSM[1], both on HREADYMUXM=1. HWDATAM = wdata_op[data_port] when wdata_phase, else 0.
- slave_sel <= HSELM on HREADYMUXM=1. HREADYMUXM = slave_sel ? HREADYOUTM : 1.

## Timing
- Reset values:
  - no_port=1, addr_port=0, rr_ptr=NUM_PORTS-1, so port 0 has first priority.
  - beats_left=0, hsel_lock=0, data_port=0, wdata_phase=0, slave_sel=0.
  - Consequently all outputs are 0 except HREADYMUXM=1.
- Grant latency: req rises in cycle n with HREADYMUXM=1 → active_op and HSELM drive that port in cycle n+1.
- Wait states (HREADYMUXM=0) freeze grant, beats_left, hsel_lock, data_port, wdata_phase and slave_sel.
- Handover from a fixed-length burst occurs on the cycle the last SEQ beat is accepted (beats_left 1→0); the new owner's address appears the following cycle. No idle bubble when another port is requesting.
- HWDATAM follows the address phase by exactly one accepted cycle.
- Asynchronous reset mid-burst returns every register to its reset value immediately; no partial burst is resumed.

## Test plan
- NUM_PORTS=4, ports 0,1,3 request SINGLE NONSEQ continuously, HREADYOUTM=1 → grants cycle 0,1,3,0,… one per cycle; port 2 (PORT_MASK=4'b1011) is never active.
- Port 1 issues an INCR8 write while port 2 requests → 8 beats are granted to port 1 back-to-back; port 2 gets HSELM in the cycle after the 8th beat is accepted; HWDATAM carries port-1 data for all 8 data phases.
- Locked sequence on port 0 with HSEL dropped for one cycle mid-lock, port 3 requesting → hsel_lock holds port 0 until HMASTLOCK falls; port 3 is granted only after that.
- HREADYOUTM=0 for 3 cycles during a WRAP4 beat → HREADYMUXM=0 for those cycles; beats_left and the grant are unchanged; the burst completes with exactly 4 beats.
- Assert HRESETn low during beat 2 of an INCR16 → in the same cycle no_port=1, HSELM=0, HREADYMUXM=1; after release, port 0 wins first when all ports request.
